k005290_shift_sequencer: RTL and testbench
==========================================

// Module: k005290_shift_sequencer
// PURPOSE
//  Sequences the two tilemap pixel shift registers (TM-A, TM-B) of the K005290 array.
//  Per layer it decides, every pixel tick, whether the register holds, loads or shifts.
//  It selects shift direction and output tap from the per-tile flip bit.
//  It applies fine horizontal scroll and blanks the layer outside the active line.
//  Sits between the video timing (hcounter/hblank) and the K005290 mode/flip inputs.
// PARAMETERS
//  TILES_PER_LINE  33  loads issued per layer per line (32 visible + 1 for scroll)
//  B_PHASE_OFS     4   pixel-phase offset of TM-B load vs TM-A (B latches at px3, A at px7)
// PORTS
//  i_EMU_MCLK         in   1  master clock
//  i_EMU_MRST         in   1  reset, asynchronous, active-high
//  i_EMU_CLK6MPCEN_n  in   1  6MHz pixel clock enable, active-low
//  i_HCNT             in   9  absolute horizontal pixel counter
//  i_HBLANK_n         in   1  0 = horizontal blank
//  i_A_HSCR / i_B_HSCR in  3  fine horizontal scroll per layer
//  i_A_TFLIP / i_B_TFLIP in 1 hflip bit of the tile whose data is in the line latch
//  o_A_MODE / o_B_MODE out 2  00 hold, 01 shift right (flipped), 10 shift left, 11 load
//  o_AFF / o_BFF      out  1  output tap select: 0 = PIXEL0, 1 = PIXEL7
//  o_A_ACTIVE / o_B_ACTIVE out 1  layer in ARM/RUN/DRAIN
// BEHAVIOUR
//  - One clock (i_EMU_MCLK); reset is asynchronous and active-high. All state changes
//    only on edges with i_EMU_CLK6MPCEN_n=0 ("tick"); otherwise everything holds.
//  - Reset: both modes 00, AFF/BFF 0, ACTIVE 0, FSMs IDLE, load counters 0, flip latches 0.
//    Reset asserted mid-line forces this state immediately; restart only at next line start.
//  - Layers are independent FSM instances; TM-B uses load phase (HSCR + B_PHASE_OFS) mod 8.
//  - Load phase: A = i_A_HSCR, B = (i_B_HSCR + B_PHASE_OFS) mod 8, 3-bit wrap.
//    Scroll is latched on ARM entry; changes mid-line are ignored until the next line.
//  - Modes are registered and computed from i_HCNT+1 (look-ahead).
//    o_x_MODE=11 is therefore presented in the tick where i_HCNT[2:0] == load phase.
//  - FSM per layer:
//    - IDLE: mode 00. i_HBLANK_n rising (0->1) -> ARM; latch scroll, clear load count.
//    - ARM: mode 00 until load phase. Then mode 11, sample TFLIP, count=1 -> RUN.
//    - RUN: mode 11 at every load phase, sampling TFLIP and incrementing count.
//      Other ticks shift: 10 if latched flip=0, 01 if 1.
//      When count reaches TILES_PER_LINE and that load has issued -> DRAIN.
//    - DRAIN: shift (latched-flip direction) exactly 8 ticks, no loads, then IDLE.
//    - Any state: i_HBLANK_n=0 -> IDLE next tick; mode 00. Blank wins over load same tick.
//  - Flip latch and o_xFF update on the tick after mode 11 issues (pixel tick of the load).
//    The first pixel of the new tile thus leaves through the correct tap. AFF/BFF hold otherwise.
//  - A load phase coinciding with the hblank rising tick is not taken; ARM waits for the next.
//  - Load counter width = clog2(TILES_PER_LINE+1); saturates, never wraps.
// TESTING
//  - Reset then HBLANK_n rises, HSCR=0, TFLIP=0 -> A_MODE: 00 until HCNT[2:0]=0, then 11,10x7 repeating.
//  - A_HSCR=5 -> first 11 at HCNT[2:0]=5; B_HSCR=0 -> B 11 at [2:0]=4; exactly 33 loads per layer.
//  - TFLIP=1 on tile 2 only -> tile 2 shifts 01 and AFF=1 from the tick after its load; tile 3 returns to 10/0.
//  - After 33rd load -> 8 shift ticks then mode 00, ACTIVE=0; HSCR change mid-line has no effect.
//  - HBLANK_n falls in RUN mid-tile -> mode 00 next tick; async reset pulse mid-line -> all outputs 0, IDLE.
//  - CLK6MPCEN_n held 1 for 5 MCLKs -> outputs and FSM frozen.

Source files
------------

// File: rtl/k005290_shift_sequencer.sv
// -----------------------------------------------------------------------------
// k005290_shift_sequencer
//
// Sequences the two tilemap pixel shift registers (TM-A and TM-B) of the
// K005290. For each layer it decides on every pixel tick whether the register
// holds, loads or shifts. It picks the shift direction and the output tap from
// the latched per-tile hflip bit. It applies the fine horizontal scroll and
// blanks the layer outside the active line.
//
// Ports
//   i_EMU_MCLK            master clock
//   i_EMU_MRST            asynchronous active-high reset
//   i_EMU_CLK6MPCEN_n     pixel clock enable, active-low (one "tick")
//   i_HCNT[8:0]           absolute horizontal pixel counter
//   i_HBLANK_n            0 = horizontal blank
//   i_A_HSCR/i_B_HSCR     fine horizontal scroll per layer
//   i_A_TFLIP/i_B_TFLIP   hflip of the tile currently in the line latch
//   o_A_MODE/o_B_MODE     00 hold, 01 shift right, 10 shift left, 11 load
//   o_AFF/o_BFF           output tap select: 0 = PIXEL0, 1 = PIXEL7
//   o_A_ACTIVE/o_B_ACTIVE layer is in ARM, RUN or DRAIN
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// k005290_layer_seq: the per-layer sequencer
//
// Ports
//   clk, rst     master clock, asynchronous active-high reset
//   tick         pixel clock enable (active-high here)
//   hcnt_la      low bits of i_HCNT + 1 (the look-ahead pixel position)
//   hblank_n     0 = horizontal blank
//   hscr         fine scroll of this layer
//   tflip        hflip of the tile in the line latch
//   mode         registered shift register mode
//   ff           registered output tap select
//   active       layer is in ARM, RUN or DRAIN
// -----------------------------------------------------------------------------
module k005290_layer_seq #(
    parameter int         TILES_PER_LINE = 33,
    parameter logic [2:0] PHASE_OFS      = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] hcnt_la,
    input  logic       hblank_n,
    input  logic [2:0] hscr,
    input  logic       tflip,
    output logic [1:0] mode,
    output logic       ff,
    output logic       active
);

    localparam int CNT_W = $clog2(TILES_PER_LINE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TILES_PER_LINE);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       drain_q, drain_d;
    logic [2:0]       phase_q, phase_d;
    logic             pend_q, pend_d;      // a load was presented last tick
    logic             flip_q, flip_d;
    logic             hblank_prev_q;

    logic             line_start;
    logic             at_phase;
    logic             flip_eff;
    logic [1:0]       shift_mode;

    assign line_start = hblank_n & ~hblank_prev_q;
    assign at_phase   = (hcnt_la == phase_q);
    // The tile loaded on the previous tick decides the direction of the very
    // first shift, so its flip bit is used directly while being latched.
    assign flip_eff   = pend_q ? tflip : flip_q;
    assign shift_mode = flip_eff ? MODE_SHR : MODE_SHL;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = MODE_HOLD;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        phase_d = phase_q;
        pend_d  = 1'b0;
        flip_d  = pend_q ? tflip : flip_q;

        case (state_q)
            S_IDLE: begin
                // A load phase landing on the line-start tick is skipped:
                // ARM only looks for the phase from the next tick on.
                if (line_start) begin
                    state_d = S_ARM;
                    phase_d = hscr + PHASE_OFS;
                    cnt_d   = '0;
                end
            end
            S_ARM: begin
                if (at_phase) begin
                    state_d = S_RUN;
                    mode_d  = MODE_LOAD;
                    cnt_d   = CNT_W'(1);
                    pend_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // Last load went out on the previous tick; empty the register.
                    state_d = S_DRAIN;
                    mode_d  = shift_mode;
                    drain_d = 3'd0;
                end else if (at_phase) begin
                    mode_d = MODE_LOAD;
                    cnt_d  = cnt_q + 1'b1;
                    pend_d = 1'b1;
                end else begin
                    mode_d = shift_mode;
                end
            end
            S_DRAIN: begin
                // Entry already issued one shift; seven more here make eight.
                if (drain_q == 3'd7) begin
                    state_d = S_IDLE;
                end else begin
                    mode_d  = shift_mode;
                    drain_d = drain_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Blank overrides everything, including a load due on this tick.
        if (!hblank_n) begin
            state_d = S_IDLE;
            mode_d  = MODE_HOLD;
            pend_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mode_q        <= MODE_HOLD;
            cnt_q         <= '0;
            drain_q       <= 3'd0;
            phase_q       <= 3'd0;
            pend_q        <= 1'b0;
            flip_q        <= 1'b0;
            // Reset high so a reset released mid-line sees no false line start.
            hblank_prev_q <= 1'b1;
        end else if (tick) begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            drain_q       <= drain_d;
            phase_q       <= phase_d;
            pend_q        <= pend_d;
            flip_q        <= flip_d;
            hblank_prev_q <= hblank_n;
        end
    end

    assign mode   = mode_q;
    assign ff     = flip_q;
    assign active = (state_q != S_IDLE);

endmodule

module k005290_shift_sequencer #(
    parameter int         TILES_PER_LINE = 33,
    parameter logic [2:0] B_PHASE_OFS    = 3'd4
) (
    input  logic       i_EMU_MCLK,
    input  logic       i_EMU_MRST,
    input  logic       i_EMU_CLK6MPCEN_n,
    input  logic [8:0] i_HCNT,
    input  logic       i_HBLANK_n,
    input  logic [2:0] i_A_HSCR,
    input  logic [2:0] i_B_HSCR,
    input  logic       i_A_TFLIP,
    input  logic       i_B_TFLIP,
    output logic [1:0] o_A_MODE,
    output logic [1:0] o_B_MODE,
    output logic       o_AFF,
    output logic       o_BFF,
    output logic       o_A_ACTIVE,
    output logic       o_B_ACTIVE
);

    logic       tick;
    logic [2:0] hcnt_la;
    logic       hcnt_hi_unused;

    assign tick    = ~i_EMU_CLK6MPCEN_n;
    // Modes are registered, so they are computed for the pixel one ahead.
    assign hcnt_la = i_HCNT[2:0] + 3'd1;
    // Only the pixel phase within a tile matters to the sequencer.
    assign hcnt_hi_unused = &{1'b0, i_HCNT[8:3]};

    k005290_layer_seq #(
        .TILES_PER_LINE (TILES_PER_LINE),
        .PHASE_OFS      (3'd0)
    ) u_layer_a (
        .clk      (i_EMU_MCLK),
        .rst      (i_EMU_MRST),
        .tick     (tick),
        .hcnt_la  (hcnt_la),
        .hblank_n (i_HBLANK_n),
        .hscr     (i_A_HSCR),
        .tflip    (i_A_TFLIP),
        .mode     (o_A_MODE),
        .ff       (o_AFF),
        .active   (o_A_ACTIVE)
    );

    k005290_layer_seq #(
        .TILES_PER_LINE (TILES_PER_LINE),
        .PHASE_OFS      (B_PHASE_OFS)
    ) u_layer_b (
        .clk      (i_EMU_MCLK),
        .rst      (i_EMU_MRST),
        .tick     (tick),
        .hcnt_la  (hcnt_la),
        .hblank_n (i_HBLANK_n),
        .hscr     (i_B_HSCR),
        .tflip    (i_B_TFLIP),
        .mode     (o_B_MODE),
        .ff       (o_BFF),
        .active   (o_B_ACTIVE)
    );

endmodule

// File: tb/tb_k005290_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_k005290_shift_sequencer
//
// Directed bench for k005290_shift_sequencer. Each line is driven like the
// video timing would: HCNT advances once per pixel tick and HBLANK_n rises at
// a chosen position. Expected outputs come from a closed-form description of
// one line, given the line-start position, the load phase, an optional
// flipped tile and an optional blank position.
// -----------------------------------------------------------------------------
module tb_k005290_shift_sequencer;

    localparam int TILES   = 33;
    localparam int NO_FLIP = 99;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen_n;
    logic [8:0] hcnt;
    logic       hblank_n;
    logic [2:0] a_hscr, b_hscr;
    logic       a_tflip, b_tflip;
    logic [1:0] a_mode, b_mode;
    logic       aff, bff, a_active, b_active;

    int checks = 0;
    int errors = 0;

    k005290_shift_sequencer dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_MRST        (rst),
        .i_EMU_CLK6MPCEN_n (cen_n),
        .i_HCNT            (hcnt),
        .i_HBLANK_n        (hblank_n),
        .i_A_HSCR          (a_hscr),
        .i_B_HSCR          (b_hscr),
        .i_A_TFLIP         (a_tflip),
        .i_B_TFLIP         (b_tflip),
        .o_A_MODE          (a_mode),
        .o_B_MODE          (b_mode),
        .o_AFF             (aff),
        .o_BFF             (bff),
        .o_A_ACTIVE        (a_active),
        .o_B_ACTIVE        (b_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int pos,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @hcnt=%0d: observed %0h expected %0h", tag, pos, obs, exp);
        end
    endtask

    // First presented position after the line-start tick whose pixel phase
    // equals the load phase.
    function automatic int first_load(input int rise_h, input int ph);
        int p;
        p = rise_h + 2;
        while ((p % 8) != ph) p++;
        return p;
    endfunction

    function automatic int tile_of(input int h, input int p0);
        if (h < p0) return -1;
        return (h - p0) / 8;
    endfunction

    // Expected {mode[1:0], active, ff} at presented position p.
    function automatic logic [3:0] model(input int p, input int p0,
                                         input int flip_tile, input int blank_at);
        int d, pf, t;
        logic [1:0] m;
        logic a, f;
        pf = (blank_at > 0 && p >= blank_at) ? blank_at - 1 : p;
        f = 1'b0;
        if (pf >= p0 + 1) begin
            t = (pf - p0 - 1) / 8;
            if (t > TILES - 1) t = TILES - 1;
            f = (t == flip_tile);
        end
        d = p - p0;
        if (p < p0)
            m = 2'b00;
        else if (d <= 8 * (TILES - 1))
            m = (d % 8 == 0) ? 2'b11 : (((d / 8) == flip_tile) ? 2'b01 : 2'b10);
        else if (d <= 8 * TILES)
            m = ((TILES - 1) == flip_tile) ? 2'b01 : 2'b10;
        else
            m = 2'b00;
        a = (p <= p0 + 8 * TILES);
        if (blank_at > 0 && p >= blank_at) begin
            m = 2'b00;
            a = 1'b0;
        end
        return {m, a, f};
    endfunction

    task automatic check_outputs(input int p, input logic [3:0] ea, input logic [3:0] eb);
        check("a_mode",   p, a_mode,   ea[3:2]);
        check("a_active", p, a_active, ea[1]);
        check("aff",      p, aff,      ea[0]);
        check("b_mode",   p, b_mode,   eb[3:2]);
        check("b_active", p, b_active, eb[1]);
        check("bff",      p, bff,      eb[0]);
    endtask

    // Drives one line. max_p = 0 runs until both layers are idle again.
    task automatic run_line(input logic [2:0] a_scr, input logic [2:0] b_scr,
                            input int rise_h, input int flip_tile,
                            input int blank_at, input int freeze_at,
                            input int scr_change_at, input logic [2:0] scr_mid,
                            input int max_p, input bit count_loads);
        int p0a, p0b, end_p, na, nb;
        logic [3:0] ea, eb;
        na = 0;
        nb = 0;
        a_hscr   = a_scr;
        b_hscr   = b_scr;
        hblank_n = 1'b0;
        hcnt     = 9'(rise_h - 3);
        repeat (3) begin
            @(posedge clk); #1;
            hcnt = hcnt + 9'd1;
        end
        p0a = first_load(rise_h, int'(a_scr));
        p0b = first_load(rise_h, (int'(b_scr) + 4) % 8);
        end_p = (max_p > 0) ? max_p : ((p0a > p0b) ? p0a : p0b) + 8 * TILES + 4;
        hblank_n = 1'b1;
        for (int h = rise_h; h < end_p; h++) begin
            a_tflip = (tile_of(h, p0a) == flip_tile);
            b_tflip = (tile_of(h, p0b) == flip_tile);
            if (blank_at > 0 && h + 1 >= blank_at) hblank_n = 1'b0;
            if (h + 1 == scr_change_at) begin
                a_hscr = scr_mid;
                b_hscr = scr_mid;
            end
            @(posedge clk); #1;
            hcnt = 9'(h + 1);
            ea = model(h + 1, p0a, flip_tile, blank_at);
            eb = model(h + 1, p0b, flip_tile, blank_at);
            check_outputs(h + 1, ea, eb);
            if (a_mode == 2'b11) na++;
            if (b_mode == 2'b11) nb++;
            if (h + 1 == freeze_at) begin
                // Wiggle inputs while the pixel enable is off; nothing may move.
                cen_n    = 1'b1;
                hcnt     = hcnt + 9'd3;
                hblank_n = 1'b0;
                a_tflip  = ~a_tflip;
                b_tflip  = ~b_tflip;
                repeat (5) begin
                    @(posedge clk); #1;
                    check_outputs(h + 1, ea, eb);
                end
                hcnt     = 9'(h + 1);
                hblank_n = 1'b1;
                cen_n    = 1'b0;
            end
        end
        if (count_loads) begin
            check("a_loads", end_p, na, TILES);
            check("b_loads", end_p, nb, TILES);
        end
    endtask

    initial begin
        rst      = 1'b1;
        cen_n    = 1'b0;
        hcnt     = 9'd0;
        hblank_n = 1'b0;
        a_hscr   = 3'd0;
        b_hscr   = 3'd0;
        a_tflip  = 1'b0;
        b_tflip  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_outputs(0, 4'b0000, 4'b0000);
        rst = 1'b0;

        // Line 1: no scroll, tile 2 flipped; A loads at [2:0]=0, B at 4.
        run_line(3'd0, 3'd0, 16, 2, 0, 0, 0, 3'd0, 0, 1'b1);

        // Line 2: A scroll 5 lands on the line-start tick and must be skipped;
        // scroll changes mid-line are ignored.
        run_line(3'd5, 3'd0, 100, NO_FLIP, 0, 0, 150, 3'd2, 0, 1'b1);

        // Line 3: blank falls mid-tile while both layers run.
        run_line(3'd3, 3'd1, 40, NO_FLIP, 80, 0, 0, 3'd0, 86, 1'b0);

        // Line 4: pixel enable held off for 5 clocks mid-line, then an
        // asynchronous reset mid-line.
        run_line(3'd0, 3'd0, 200, NO_FLIP, 0, 230, 0, 3'd0, 260, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_outputs(260, 4'b0000, 4'b0000);
        #2 rst = 1'b0;
        for (int h = 260; h < 272; h++) begin
            @(posedge clk); #1;
            hcnt = 9'(h + 1);
            check_outputs(h + 1, 4'b0000, 4'b0000);
        end

        // Line 5: a clean line start after the reset restarts both layers.
        run_line(3'd2, 3'd6, 300, 0, 0, 0, 0, 3'd0, 330, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
